// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcodes and small decode helpers for the issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // The alternate funct7 encoding only exists for SUB and SRA/SRAI.
    function automatic logic funct7_ok(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    endfunction

    // EX/MEM is younger than MEM/WB, so it wins; x0 never forwards.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        ex_we,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_data,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        if (rs == 5'd0)                     return 32'd0;
        else if (ex_we && (ex_rd == rs))    return ex_data;
        else if (wb_we && (wb_rd == rs))    return wb_data;
        else                                return rf_data;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction (I, S and U formats, sign-extended).
module imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'd0};

endmodule

// File: rtl/ex_issue_stage.sv
// Decode/operand-select issue stage: forwards rs1/rs2, builds ALU operands and holds
// them in a one-entry valid/ready register toward the ALU stage.
module ex_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             exmem_we,
    input  logic [4:0]       exmem_rd,
    input  logic [31:0]      exmem_data,
    input  logic             memwb_we,
    input  logic [4:0]       memwb_rd,
    input  logic [31:0]      memwb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [3:0]       ALUOp,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic [31:0]      store_data,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_f, rs2_f, imm_i, imm_s, imm_u;
    logic        xfer;

    logic [31:0] a_d, b_d, store_d;
    logic [3:0]  alu_op_d;
    logic        rd_we_d, illegal_d;

    logic             valid_q, rd_we_q, illegal_q;
    logic [31:0]      a_q, b_q, store_q;
    logic [3:0]       alu_op_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign funct7  = instr[31:25];

    assign rs1_f = fwd_operand(rs1_idx, rs1_data, exmem_we, exmem_rd, exmem_data,
                               memwb_we, memwb_rd, memwb_data);
    assign rs2_f = fwd_operand(rs2_idx, rs2_data, exmem_we, exmem_rd, exmem_data,
                               memwb_we, memwb_rd, memwb_data);

    imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u)
    );

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign xfer     = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        store_d   = '0;
        alu_op_d  = ALU_ADD;
        rd_we_d   = 1'b0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_OP: begin
                a_d       = rs1_f;
                b_d       = rs2_f;
                alu_op_d  = {instr[30], funct3};
                rd_we_d   = 1'b1;
                illegal_d = !funct7_ok(funct7, funct3);
            end
            OPC_OP_IMM: begin
                a_d     = rs1_f;
                rd_we_d = 1'b1;
                // Shift immediates carry funct7 in the upper bits; B is the bare shamt.
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    b_d       = {27'd0, instr[24:20]};
                    alu_op_d  = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
                    illegal_d = !funct7_ok(funct7, funct3);
                end else begin
                    b_d      = imm_i;
                    alu_op_d = {1'b0, funct3};
                end
            end
            OPC_LUI: begin
                b_d     = imm_u;
                rd_we_d = 1'b1;
            end
            OPC_AUIPC: begin
                a_d     = pc;
                b_d     = imm_u;
                rd_we_d = 1'b1;
            end
            OPC_LOAD: begin
                a_d     = rs1_f;
                b_d     = imm_i;
                rd_we_d = 1'b1;
            end
            OPC_STORE: begin
                a_d     = rs1_f;
                b_d     = imm_s;
                store_d = rs2_f;
            end
            OPC_JAL, OPC_JALR: begin
                a_d     = pc;
                b_d     = 32'd4;
                rd_we_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            a_d      = '0;
            b_d      = '0;
            store_d  = '0;
            alu_op_d = ALU_ADD;
            rd_we_d  = 1'b0;
        end
        if (rd_idx == 5'd0) rd_we_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            alu_op_q  <= ALU_ADD;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            store_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (xfer) begin
            valid_q   <= 1'b1;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_op_q  <= alu_op_d;
            rd_q      <= rd_idx;
            rd_we_q   <= rd_we_d;
            store_q   <= store_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_q + CNT_W'(1);
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign A          = a_q;
    assign B          = b_q;
    assign ALUOp      = alu_op_q;
    assign rd         = rd_q;
    assign rd_we      = rd_we_q;
    assign store_data = store_q;
    assign illegal    = illegal_q;
    assign issue_cnt  = cnt_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage (CNT_W=4): decode, forwarding, backpressure,
// flush, counter wrap and asynchronous reset, with hand-computed expectations.
module tb_ex_issue_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        exmem_we, memwb_we;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] A, B, store_data;
    logic [3:0]  ALUOp;
    logic [4:0]  rd;
    logic        rd_we, illegal;
    logic [3:0]  issue_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] exp_cnt = 4'd0;

    ex_issue_stage #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .rd         (rd),
        .rd_we      (rd_we),
        .store_data (store_data),
        .illegal    (illegal),
        .issue_cnt  (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_A"}, A, 32'd0);
        check({tag, "_B"}, B, 32'd0);
        check({tag, "_ALUOp"}, 32'(ALUOp), 32'd0);
        check({tag, "_rd"}, 32'(rd), 32'd0);
        check({tag, "_rd_we"}, 32'(rd_we), 32'd0);
        check({tag, "_store_data"}, store_data, 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One accepted operation; called one time unit after a rising edge.
    task automatic send(input string tag, input logic [31:0] ins);
        in_valid = 1'b1;
        instr    = ins;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_cnt  = exp_cnt + 4'd1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
        exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
        #1;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADDI x1,x2,-1
        rs1_data = 32'd5;
        send("addi", 32'hFFF10093);
        check("addi_A", A, 32'd5);
        check("addi_B", B, 32'hFFFF_FFFF);
        check("addi_ALUOp", 32'(ALUOp), 32'h0);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_rd_we", 32'(rd_we), 32'd1);
        check("addi_illegal", 32'(illegal), 32'd0);

        // SUB x3,x1,x2: both stages target x1, EX/MEM wins
        rs1_data = 32'h11; rs2_data = 32'h22;
        exmem_we = 1'b1; exmem_rd = 5'd1; exmem_data = 32'd9;
        memwb_we = 1'b1; memwb_rd = 5'd1; memwb_data = 32'd7;
        send("sub_fwd", 32'h402081B3);
        check("sub_fwd_A", A, 32'd9);
        check("sub_fwd_B", B, 32'h22);
        check("sub_fwd_ALUOp", 32'(ALUOp), 32'h8);
        check("sub_fwd_rd", 32'(rd), 32'd3);

        // MEM/WB only forwards rs2
        exmem_rd = 5'd5; memwb_rd = 5'd2;
        send("sub_wb", 32'h402081B3);
        check("sub_wb_A", A, 32'h11);
        check("sub_wb_B", B, 32'd7);

        // SUB x3,x0,x2 with forwarding sources at x0
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        send("sub_x0", 32'h402001B3);
        check("sub_x0_A", A, 32'd0);
        check("sub_x0_B", B, 32'h22);
        exmem_we = 1'b0; memwb_we = 1'b0;

        // SRAI x4,x4,3
        rs1_data = 32'h80;
        send("srai", 32'h40325213);
        check("srai_ALUOp", 32'(ALUOp), 32'hD);
        check("srai_B", B, 32'd3);
        check("srai_A", A, 32'h80);
        check("srai_illegal", 32'(illegal), 32'd0);

        // ADDI / XORI with imm[11:5]=0100000
        send("addi_alt", 32'h40000293);
        check("addi_alt_ALUOp", 32'(ALUOp), 32'h0);
        check("addi_alt_B", B, 32'h400);
        check("addi_alt_illegal", 32'(illegal), 32'd0);
        send("xori_alt", 32'h40004293);
        check("xori_alt_ALUOp", 32'(ALUOp), 32'h4);
        check("xori_alt_B", B, 32'h400);

        // SLLI with funct7=0100000 is illegal
        send("slli_bad", 32'h40109313);
        check("slli_bad_illegal", 32'(illegal), 32'd1);
        check("slli_bad_A", A, 32'd0);
        check("slli_bad_B", B, 32'd0);
        check("slli_bad_ALUOp", 32'(ALUOp), 32'h0);
        check("slli_bad_rd_we", 32'(rd_we), 32'd0);

        // LUI x7,0x12345 and AUIPC x7,0x80000
        send("lui", 32'h123453B7);
        check("lui_A", A, 32'd0);
        check("lui_B", B, 32'h1234_5000);
        check("lui_rd", 32'(rd), 32'd7);
        check("lui_rd_we", 32'(rd_we), 32'd1);
        pc = 32'h1000;
        send("auipc", 32'h80000397);
        check("auipc_A", A, 32'h1000);
        check("auipc_B", B, 32'h8000_0000);

        // SW x2,-4(x1) with rs2 forwarded from EX/MEM
        rs1_data = 32'h100; rs2_data = 32'hABCD;
        exmem_we = 1'b1; exmem_rd = 5'd2; exmem_data = 32'h55;
        send("sw", 32'hFE20AE23);
        check("sw_A", A, 32'h100);
        check("sw_B", B, 32'hFFFF_FFFC);
        check("sw_store_data", store_data, 32'h55);
        check("sw_rd_we", 32'(rd_we), 32'd0);
        check("sw_ALUOp", 32'(ALUOp), 32'h0);
        exmem_we = 1'b0;

        // JAL x1,+8
        pc = 32'h2000;
        send("jal", 32'h008000EF);
        check("jal_A", A, 32'h2000);
        check("jal_B", B, 32'd4);
        check("jal_rd_we", 32'(rd_we), 32'd1);

        // ADDI x0,x0,0 never writes; BEQ is not issued here
        send("nop", 32'h00000013);
        check("nop_rd_we", 32'(rd_we), 32'd0);
        check("nop_illegal", 32'(illegal), 32'd0);
        send("beq", 32'h00000063);
        check("beq_illegal", 32'(illegal), 32'd1);
        check("beq_rd_we", 32'(rd_we), 32'd0);
        check("cnt_14", 32'(issue_cnt), 32'(exp_cnt));

        // Backpressure: the 15th transfer brings the counter to all-ones
        rs1_data = 32'd5;
        send("bp_load", 32'hFFF10093);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h123453B7;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_A", A, 32'd5);
            check("bp_B", B, 32'hFFFF_FFFF);
            check("bp_rd", 32'(rd), 32'd1);
            check("bp_cnt", 32'(issue_cnt), 32'(exp_cnt));
        end
        check("bp_cnt_all_ones", 32'(issue_cnt), 32'hF);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 4'd1;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_B", B, 32'h1234_5000);
        check("b2b_rd", 32'(rd), 32'd7);
        check("wrap_cnt", 32'(issue_cnt), 32'(exp_cnt));

        // Flush with a held op and a new op offered
        instr = 32'hFFF10093;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(issue_cnt), 32'(exp_cnt));
        check("flush_B_kept", B, 32'h1234_5000);

        // Asynchronous reset while holding an operation
        send("hold", 32'hFFF10093);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_cnt", 32'(issue_cnt), 32'(exp_cnt));
        #2;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #1;
        check_reset("midreset");
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
